// File: rtl/rom_arbiter_if.sv
// Request/ROM bundle for rom_arbiter.
// master: the arbiter side (takes requests, drives the ROM).
// slave : the environment side (requesters and ROM).
interface rom_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              i_req0;
  logic [ADDR_W-1:0] i_addr0;
  logic              o_ack0;
  logic              o_err0;
  logic              i_req1;
  logic [ADDR_W-1:0] i_addr1;
  logic              o_ack1;
  logic              o_err1;
  logic [DATA_W-1:0] o_data;
  logic              o_busy;
  logic              o_rom_read;
  logic [ADDR_W-1:0] o_rom_address;
  logic [DATA_W-1:0] i_rom_data;
  logic              i_rom_valid;

  modport master (
    input  i_req0, i_addr0, i_req1, i_addr1, i_rom_data, i_rom_valid,
    output o_ack0, o_err0, o_ack1, o_err1, o_data, o_busy,
           o_rom_read, o_rom_address
  );

  modport slave (
    output i_req0, i_addr0, i_req1, i_addr1, i_rom_data, i_rom_valid,
    input  o_ack0, o_err0, o_ack1, o_err1, o_data, o_busy,
           o_rom_read, o_rom_address
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-client round-robin arbiter and read sequencer for the sprite/font ROM.
// Requester 0 is the sprite fetcher, requester 1 the font renderer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; no arbitration while ack/err is high
// ISSUE | read strobe high for one cycle, address held
// WAIT  | waiting for ROM valid; watchdog counts toward TIMEOUT-1
module rom_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rom_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Watchdog fires on the WAIT cycle whose count equals this value.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        tmo_cnt;
  logic              grant;
  logic              last_grant;
  logic              pick;
  logic              resp_pending;

  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic              busy;
  logic              rom_read;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] data;

  assign resp_pending = ack0 | ack1 | err0 | err1;

  // Round-robin choice: a lone request wins, a tie goes to whoever did not win last.
  always_comb begin
    pick = 1'b0;
    if (bus.i_req0 && bus.i_req1) begin
      pick = ~last_grant;
    end else if (bus.i_req1) begin
      pick = 1'b1;
    end
  end

  // Sequencer: arbitration, read strobe, watchdog and registered responses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      busy        <= 1'b0;
      rom_read    <= 1'b0;
      rom_address <= '0;
      data        <= '0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rom_read <= 1'b0;

      case (state)
        IDLE: begin
          // The response cycle is skipped so the owner can drop req or move its address.
          if (!resp_pending && (bus.i_req0 || bus.i_req1)) begin
            grant       <= pick;
            rom_address <= pick ? bus.i_addr1 : bus.i_addr0;
            rom_read    <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          // Valid takes priority over the watchdog on the final count.
          if (bus.i_rom_valid) begin
            data       <= bus.i_rom_data;
            ack0       <= ~grant;
            ack1       <= grant;
            last_grant <= grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err0       <= ~grant;
            err1       <= grant;
            last_grant <= grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_ack0        = ack0;
  assign bus.o_ack1        = ack1;
  assign bus.o_err0        = err0;
  assign bus.o_err1        = err1;
  assign bus.o_busy        = busy;
  assign bus.o_rom_read    = rom_read;
  assign bus.o_rom_address = rom_address;
  assign bus.o_data        = data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: requester drivers, a ROM responder that posts the
// expected outcome of every read, and a transaction-level monitor.
module tb_rom_arbiter;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic i_clk = 1'b0;
  logic i_rst_n;

  rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rom_word(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sbq[$];

  // ROM responder: picks a latency per read and posts the expected outcome.
  int rsp_mode = 1;
  bit spur_en  = 1'b0;

  initial begin
    bus.i_rom_valid = 1'b0;
    bus.i_rom_data  = '0;
    forever begin
      int         lat;
      int         r;
      logic [7:0] a;
      exp_t       e;
      @(negedge i_clk);
      bus.i_rom_valid = 1'b0;
      if (i_rst_n && bus.o_rom_read === 1'b1) begin
        a = bus.o_rom_address;
        if (rsp_mode != 0) begin
          lat = rsp_mode;
        end else begin
          r = int'($urandom % 8);
          if (r < 5)       lat = 1 + int'($urandom % 4);
          else if (r == 5) lat = TIMEOUT;
          else if (r == 6) lat = TIMEOUT + 1;
          else             lat = NEVER;
        end
        e.is_err = (lat > TIMEOUT);
        e.data   = rom_word(a);
        e.due    = cyc + (e.is_err ? TIMEOUT + 1 : lat + 1);
        sbq.push_back(e);
        if (lat <= TIMEOUT + 1) begin
          repeat (lat) @(negedge i_clk);
          bus.i_rom_data  = rom_word(a);
          bus.i_rom_valid = 1'b1;
          @(negedge i_clk);
          bus.i_rom_valid = 1'b0;
        end
      end else if (spur_en && i_rst_n && bus.o_busy === 1'b0 && ($urandom % 8) == 0) begin
        bus.i_rom_data  = 8'($urandom);
        bus.i_rom_valid = 1'b1;
      end
    end
  end

  // Monitor / reference model: when a read must occur, who owns it, and what answer comes back.
  bit         m_out;
  bit         m_resp_prev;
  bit         m_last;
  bit         m_owner;
  logic [7:0] m_data;
  logic       p_req0, p_req1;
  logic [7:0] p_addr0, p_addr1;

  always @(negedge i_clk) begin
    int   nresp;
    bit   exp_read;
    bit   g;
    exp_t e;
    if (!i_rst_n) begin
      chk("rst_ack0", 32'(bus.o_ack0), 32'(0));
      chk("rst_ack1", 32'(bus.o_ack1), 32'(0));
      chk("rst_err0", 32'(bus.o_err0), 32'(0));
      chk("rst_err1", 32'(bus.o_err1), 32'(0));
      chk("rst_busy", 32'(bus.o_busy), 32'(0));
      chk("rst_read", 32'(bus.o_rom_read), 32'(0));
      chk("rst_addr", 32'(bus.o_rom_address), 32'(0));
      chk("rst_data", 32'(bus.o_data), 32'(0));
      m_out       = 1'b0;
      m_resp_prev = 1'b0;
      m_last      = 1'b1;
      m_owner     = 1'b0;
      m_data      = '0;
      p_req0      = 1'b0;
      p_req1      = 1'b0;
      p_addr0     = '0;
      p_addr1     = '0;
      sbq.delete();
    end else begin
      nresp = int'(bus.o_ack0) + int'(bus.o_ack1) + int'(bus.o_err0) + int'(bus.o_err1);
      exp_read = !m_out && !m_resp_prev && (p_req0 || p_req1);
      chk("rom_read", 32'(bus.o_rom_read), 32'(exp_read));
      if (exp_read && bus.o_rom_read === 1'b1) begin
        g = (p_req0 && p_req1) ? !m_last : p_req1;
        chk("grant_addr", 32'(bus.o_rom_address), 32'(g ? p_addr1 : p_addr0));
        m_owner = g;
        m_last  = g;
        m_out   = 1'b1;
      end
      m_resp_prev = 1'b0;
      chk("resp_onehot", 32'(nresp <= 1), 32'(1));
      if (nresp != 0) begin
        m_resp_prev = 1'b1;
        if (sbq.size() == 0) begin
          chk("resp_unexpected", 32'(nresp), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          chk("resp_ack0", 32'(bus.o_ack0), 32'(!e.is_err && !m_owner));
          chk("resp_ack1", 32'(bus.o_ack1), 32'(!e.is_err && m_owner));
          chk("resp_err0", 32'(bus.o_err0), 32'(e.is_err && !m_owner));
          chk("resp_err1", 32'(bus.o_err1), 32'(e.is_err && m_owner));
          if (!e.is_err) m_data = e.data;
          m_out = 1'b0;
        end
      end else if (sbq.size() != 0 && cyc >= sbq[0].due) begin
        chk("resp_missing", 32'(nresp), 32'(1));
        void'(sbq.pop_front());
        m_out = 1'b0;
      end
      chk("busy", 32'(bus.o_busy), 32'(m_out));
      chk("data", 32'(bus.o_data), 32'(m_data));
      p_req0  = bus.i_req0;
      p_req1  = bus.i_req1;
      p_addr0 = bus.i_addr0;
      p_addr1 = bus.i_addr1;
    end
  end

  task automatic set_req(input int id, input logic r, input logic [7:0] a);
    if (id == 0) begin
      bus.i_req0  = r;
      bus.i_addr0 = a;
    end else begin
      bus.i_req1  = r;
      bus.i_addr1 = a;
    end
  endtask

  function automatic logic got_resp(input int id);
    return (id == 0) ? (bus.o_ack0 | bus.o_err0) : (bus.o_ack1 | bus.o_err1);
  endfunction

  // One requester: n transactions, holding req until its ack/err.
  task automatic run_req(input int id, input int n, input logic [7:0] base,
                         input int step, input bit rnd);
    logic [7:0] a;
    int         gap;
    int         waited;
    bit         dropped;
    a = base;
    for (int i = 0; i < n; i++) begin
      a = rnd ? {id[0], 7'($urandom)} : 8'(int'(base) + step * i);
      set_req(id, 1'b1, a);
      waited  = 0;
      dropped = 1'b0;
      do begin
        @(posedge i_clk);
        #1;
        waited++;
        if (rnd && !dropped && bus.o_rom_read === 1'b1 && bus.o_rom_address == a
            && ($urandom % 4) == 0) begin
          set_req(id, 1'b0, a);
          dropped = 1'b1;
        end
      end while (!got_resp(id) && waited < 400);
      chk("req_wait", 32'(got_resp(id)), 32'(1));
      gap = rnd ? int'($urandom % 4) : 0;
      if (gap > 0 || i == n - 1) begin
        set_req(id, 1'b0, a);
        repeat (gap) @(posedge i_clk);
        #1;
      end
    end
    set_req(id, 1'b0, a);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int w;
    bus.i_req0  = 1'b0;
    bus.i_req1  = 1'b0;
    bus.i_addr0 = '0;
    bus.i_addr1 = '0;
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    idle_cycles(3);
    i_rst_n = 1'b1;
    idle_cycles(2);

    // Single read, L=1.
    rsp_mode = 1;
    run_req(0, 1, 8'h10, 0, 1'b0);
    chk("single_data", 32'(bus.o_data), 32'(8'hB5));
    idle_cycles(4);

    // Contention with continuous requests.
    fork
      run_req(0, 4, 8'h01, 0, 1'b0);
      run_req(1, 4, 8'h02, 0, 1'b0);
    join
    idle_cycles(4);

    // Held request moves to a new address right after its ack.
    run_req(1, 2, 8'h20, 1, 1'b0);
    idle_cycles(4);

    // Timeout, then a normal read.
    rsp_mode = NEVER;
    run_req(1, 1, 8'h30, 0, 1'b0);
    chk("timeout_data_held", 32'(bus.o_data), 32'(rom_word(8'h21)));
    rsp_mode = 1;
    run_req(0, 1, 8'h31, 0, 1'b0);
    idle_cycles(4);

    // Valid on the last WAIT cycle, then one cycle too late.
    rsp_mode = TIMEOUT;
    run_req(0, 1, 8'h40, 0, 1'b0);
    rsp_mode = TIMEOUT + 1;
    run_req(1, 1, 8'h41, 0, 1'b0);
    idle_cycles(4);

    // Randomized traffic with spurious idle valids and mid-transaction req drops.
    rsp_mode = 0;
    spur_en  = 1'b1;
    fork
      run_req(0, 30, 8'h00, 0, 1'b1);
      run_req(1, 30, 8'h00, 0, 1'b1);
    join
    spur_en  = 1'b0;
    rsp_mode = 1;
    idle_cycles(TIMEOUT + 6);

    // Async reset while waiting on the ROM; its late valid must be ignored.
    rsp_mode = 6;
    set_req(0, 1'b1, 8'h33);
    w = 0;
    do begin
      @(posedge i_clk);
      #1;
      w++;
    end while (bus.o_rom_read !== 1'b1 && w < 50);
    chk("rst_read_seen", 32'(bus.o_rom_read), 32'(1));
    repeat (2) @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    set_req(0, 1'b0, 8'h00);
    #1;
    chk("async_ack0", 32'(bus.o_ack0), 32'(0));
    chk("async_busy", 32'(bus.o_busy), 32'(0));
    chk("async_read", 32'(bus.o_rom_read), 32'(0));
    chk("async_addr", 32'(bus.o_rom_address), 32'(0));
    chk("async_data", 32'(bus.o_data), 32'(0));
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle_cycles(10);
    rsp_mode = 1;
    fork
      run_req(0, 1, 8'h44, 0, 1'b0);
      run_req(1, 1, 8'h45, 0, 1'b0);
    join
    idle_cycles(TIMEOUT + 6);
    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port sprite/font ROM.
- Accepts address requests from two clients (req0: paddle/ball sprite fetcher, req1: score/font renderer) and grants the ROM round-robin.
- Drives the ROM read pulse and address, waits for the ROM valid strobe, then returns registered data with a per-requester ack.
- A watchdog aborts any read whose valid never arrives and flags an error to the owning requester.

Parameters:
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width.
- TIMEOUT, 16, WAIT cycles without valid before abort; legal range 2..255.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req0  in  1  requester 0 request; held high with i_addr0 stable until o_ack0/o_err0.
- i_addr0  in  ADDR_W  requester 0 address.
- o_ack0  out  1  one-cycle pulse: o_data valid for requester 0.
- o_err0  out  1  one-cycle pulse: requester 0 read timed out.
- i_req1  in  1  requester 1 request; same rules as req0.
- i_addr1  in  ADDR_W  requester 1 address.
- o_ack1  out  1  one-cycle pulse: o_data valid for requester 1.
- o_err1  out  1  one-cycle pulse: requester 1 read timed out.
- o_data  out  DATA_W  last ROM word returned; holds until the next successful read.
- o_busy  out  1  high in ISSUE and WAIT.
- o_rom_read  out  1  one-cycle read strobe to the ROM.
- o_rom_address  out  ADDR_W  registered address to the ROM; stable from ISSUE through WAIT.
- i_rom_data  in  DATA_W  ROM data.
- i_rom_valid  in  1  ROM data-valid strobe; earliest one cycle after o_rom_read.

Behaviour:
- Reset (async, i_rst_n=0), all registered, cleared immediately:
  - state=IDLE.
  - o_ack0/1=0, o_err0/1=0, o_busy=0, o_rom_read=0.
  - o_rom_address=0, o_data=0.
  - last_grant=1, so requester 0 wins the first contention.
  - timeout counter=0.
- Reset mid-transaction: the transaction is dropped with no ack and no err. A later i_rom_valid is ignored, because the FSM is in IDLE.
- State IDLE:
  - If any of o_ack0/1/o_err0/1 is high this cycle, do not arbitrate. This blocking cycle lets the requester drop req or present a new address.
  - Otherwise, if any req is high, grant:
    - Only one req high: grant it.
    - Both high: grant the requester that is not last_grant.
  - On grant: latch the granted address into o_rom_address, record grant, go to ISSUE.
- State ISSUE:
  - o_rom_read=1 for exactly this cycle; o_busy=1.
  - Clear the timeout counter, go to WAIT.
- State WAIT:
  - o_rom_read=0, o_busy=1, counter increments each cycle.
  - i_rom_valid=1: o_data<=i_rom_data, pulse ack for the granted requester on the next cycle, last_grant<=grant, go to IDLE.
  - Counter reaches TIMEOUT-1 with no valid: pulse err for the granted requester, last_grant<=grant, go to IDLE, o_data unchanged.
  - Valid on the same cycle the counter hits TIMEOUT-1: valid wins, ack is issued, no err.
- Outputs ack/err are registered and asserted during the first IDLE cycle after WAIT. Exactly one of the four is high in any cycle, or none.
- i_rom_valid in IDLE or ISSUE is ignored.
- Request change while granted: req/addr of the granted requester are not re-sampled after IDLE. Deasserting req mid-transaction does not cancel it; ack/err is still pulsed.
- Latency with ROM valid L cycles after read (L≥1):
  - req sampled (IDLE edge) → read strobe: 1 cycle.
  - read strobe → ack: L+1 cycles.
  - Back-to-back period per transaction: L+3 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1…

Test Plan:
- Reset then single read: ROM model returns data=addr^8'hA5, L=1; i_req0=1, i_addr0=8'h10 → o_rom_read one pulse with o_rom_address=8'h10; o_ack0 pulses 2 cycles after the read; o_data=8'hB5; o_ack1/o_err*=0.
- Contention: i_req0 and i_req1 both high continuously from reset, addr0=8'h01, addr1=8'h02 → reads alternate 01,02,01,02; acks alternate ack0,ack1; period 4 cycles at L=1.
- Held request after ack: requester 1 keeps i_req1 high with a new address (8'h20 then 8'h21) the cycle after ack → no duplicate read of 8'h20; next read is 8'h21.
- Timeout: ROM model never asserts valid, i_req1=1 → o_err1 pulses exactly TIMEOUT+1 cycles after o_rom_read (17 at default); o_data keeps its previous value; next req0 is served normally.
- Valid at the timeout boundary: valid arrives in the last WAIT cycle (counter=TIMEOUT-1) → ack issued, no err.
- Async reset in WAIT: assert i_rst_n=0 between the read and valid → all outputs 0 immediately; a late i_rom_valid produces no ack; after release, the first contention grants requester 0.
